digital_lock_ctrl: RTL and testbench
====================================

Name: digital_lock_ctrl

Overview:
- Control FSM for the DE1 digital lock.
- Collects BCD key digits, compares the entry against a stored code, and drives unlocked status.
- Produces the Error flag consumed directly by the downstream "Error" 7-segment encoder.
- Adds a failed-attempt counter with timed lockout, plus code change while unlocked.

Parameters:
- NUM_DIGITS, 4: code length in BCD digits.
- MAX_ATTEMPTS, 3: consecutive failures that trigger lockout (≥1).
- ERROR_CYCLES, 50_000_000: cycles Error is held after a single failure (≥1).
- LOCKOUT_CYCLES, 500_000_000: cycles held in lockout (≥1).
- UNLOCK_CYCLES, 500_000_000: auto-relock timeout (≥1).
- DEFAULT_CODE, 16'h1234: code loaded at reset, width 4*NUM_DIGITS.

Ports:
- clk, in, 1: system clock; all logic on rising edge.
- rst_n, in, 1: synchronous active-low reset.
- key_valid, in, 1: one-cycle strobe; key_digit valid.
- key_digit, in, 4: BCD digit; values >9 are ignored.
- enter, in, 1: one-cycle strobe; submit the entry.
- clear, in, 1: one-cycle strobe; discard the entry.
- lock, in, 1: one-cycle strobe; relock from UNLOCKED.
- set_code, in, 1: one-cycle strobe; store the entry as the new code (UNLOCKED only).
- entry_digits, out, 4*NUM_DIGITS: entered digits, newest in bits [3:0], for display.
- digit_count, out, clog2(NUM_DIGITS+1): number of digits entered.
- unlocked, out, 1: high in UNLOCKED.
- Error, out, 1: high in ERROR and LOCKOUT; drives the Error 7-segment encoder.
- lockout, out, 1: high in LOCKOUT.
- fail_count, out, clog2(MAX_ATTEMPTS+1): consecutive failures.

Behaviour:
- One clock domain; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values:
  - state = ENTRY.
  - code = DEFAULT_CODE.
  - entry_digits = 0, digit_count = 0, fail_count = 0, timer = 0.
  - unlocked = 0, Error = 0, lockout = 0.
- Reset overrides everything, including mid-error, mid-lockout and mid-unlock.
- Status outputs are Moore decodes of the registered state. No combinational path from inputs to unlocked, Error or lockout.
- Digit capture:
  - Capture happens in ENTRY and UNLOCKED.
  - Applies when key_valid=1, key_digit≤9 and digit_count<NUM_DIGITS.
  - entry_digits <= {entry_digits[4*NUM_DIGITS-5:0], key_digit}; digit_count increments.
  - Keys arriving at full count, or with key_digit>9, are dropped with no state change.
- ENTRY, priority clear > enter > key_valid:
  - clear: entry_digits = 0, digit_count = 0.
  - enter: go to CHECK. A partial entry, including digit_count = 0, is still checked and counts as a failure.
- CHECK (exactly one cycle; all inputs ignored):
  - Pass when digit_count==NUM_DIGITS and entry_digits==code.
  - Pass → UNLOCKED, fail_count = 0, timer = 0.
  - Fail with fail_count+1 == MAX_ATTEMPTS → LOCKOUT, fail_count saturates at MAX_ATTEMPTS.
  - Fail otherwise → ERROR, fail_count increments.
  - Entry is cleared on every CHECK exit.
- ERROR:
  - Error=1 for exactly ERROR_CYCLES cycles, then ENTRY.
  - All key inputs are ignored and the entry stays cleared.
- LOCKOUT:
  - Error=1 and lockout=1 for exactly LOCKOUT_CYCLES cycles.
  - Then ENTRY with fail_count = 0.
  - All inputs ignored.
- UNLOCKED, priority lock > set_code > clear > key_valid:
  - lock: go to ENTRY, entry cleared.
  - set_code with digit_count==NUM_DIGITS: code <= entry_digits, entry cleared, timer restarts, stay UNLOCKED.
  - set_code with a partial entry: ignored.
  - Timer reaching UNLOCK_CYCLES-1 with no lock or set_code event: go to ENTRY, entry cleared.
  - Any accepted key or set_code restarts the timer.
- Timing:
  - enter sampled at edge k gives CHECK after edge k.
  - unlocked or Error is high after edge k+1, i.e. 2-cycle latency.
- Error and unlocked are never high together.
- One shared timer is used; it is zeroed on every state change.

Test Plan (ERROR_CYCLES=4, LOCKOUT_CYCLES=8, UNLOCK_CYCLES=16, MAX_ATTEMPTS=3, DEFAULT_CODE=16'h1234):
- Correct code: after reset, keys 1,2,3,4 then enter. Required: entry_digits=16'h1234 and digit_count=4 before enter; unlocked=1 exactly 2 cycles after enter; Error=0; fail_count=0.
- Single failure and recovery: keys 1,2,3,5 then enter. Required: Error=1 for exactly 4 cycles; fail_count=1; keys during ERROR ignored; then ENTRY with digit_count=0. Next, 1,2,3,4 + enter → unlocked, fail_count=0.
- Lockout: three wrong entries, including one enter with only 2 digits. Required: third failure gives lockout=1 and Error=1 for 8 cycles; fail_count=3; then fail_count=0; the correct code afterwards unlocks.
- Input filtering: key_digit=4'hA ignored; a 5th digit ignored; clear and key_valid in the same cycle → digit_count=0; clear and enter together → no CHECK.
- Code change: unlock, enter 9,8,7,6, set_code, then lock. Required: code 1234 now fails; 9876 unlocks. set_code with only 3 digits leaves the code unchanged.
- Timeout and reset: unlocked with no input for 16 cycles → relock. rst_n=0 for one cycle mid-LOCKOUT → all outputs 0 next cycle and code=16'h1234.

Source files
------------

// File: rtl/digital_lock_ctrl.sv
// Digital lock control FSM: BCD code entry, compare, timed error/lockout,
// auto-relock and code change while unlocked.
module digital_lock_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int ERROR_CYCLES   = 50_000_000,
  parameter int LOCKOUT_CYCLES = 500_000_000,
  parameter int UNLOCK_CYCLES  = 500_000_000,
  parameter logic [4*NUM_DIGITS-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              key_valid,
  input  logic [3:0]                        key_digit,
  input  logic                              enter,
  input  logic                              clear,
  input  logic                              lock,
  input  logic                              set_code,
  output logic [4*NUM_DIGITS-1:0]           entry_digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
  output logic                              unlocked,
  output logic                              Error,
  output logic                              lockout,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] fail_count
);

  localparam int DW  = 4 * NUM_DIGITS;
  localparam int CW  = $clog2(NUM_DIGITS + 1);
  localparam int FW  = $clog2(MAX_ATTEMPTS + 1);
  localparam int MC1 = (ERROR_CYCLES > LOCKOUT_CYCLES) ?
                       ERROR_CYCLES : LOCKOUT_CYCLES;
  localparam int MC  = (MC1 > UNLOCK_CYCLES) ? MC1 : UNLOCK_CYCLES;
  localparam int TW  = $clog2(MC + 1);

  localparam logic [CW-1:0] FULL      = CW'(NUM_DIGITS);
  localparam logic [TW-1:0] ERR_END   = TW'(ERROR_CYCLES - 1);
  localparam logic [TW-1:0] LCK_END   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] UNL_END   = TW'(UNLOCK_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_ATTEMPTS - 1);
  localparam logic [FW-1:0] FAIL_SAT  = FW'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    S_ENTRY,
    S_CHECK,
    S_ERROR,
    S_LOCKOUT,
    S_UNLOCKED
  } state_t;

  state_t        state;
  logic [DW-1:0] code;
  logic [TW-1:0] timer;

  logic          key_ok;
  logic          code_ok;
  logic          full;
  logic [DW-1:0] shifted;

  assign full    = (digit_count == FULL);
  assign key_ok  = key_valid && (key_digit <= 4'd9) && !full;
  assign code_ok = full && (entry_digits == code);
  assign shifted = {entry_digits[DW-5:0], key_digit};

  assign unlocked = (state == S_UNLOCKED);
  assign Error    = (state == S_ERROR) || (state == S_LOCKOUT);
  assign lockout  = (state == S_LOCKOUT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_ENTRY;
      code         <= DEFAULT_CODE;
      entry_digits <= '0;
      digit_count  <= '0;
      fail_count   <= '0;
      timer        <= '0;
    end else begin
      unique case (state)
        S_ENTRY: begin
          if (clear) begin
            entry_digits <= '0;
            digit_count  <= '0;
          end else if (enter) begin
            state <= S_CHECK;
            timer <= '0;
          end else if (key_ok) begin
            entry_digits <= shifted;
            digit_count  <= digit_count + CW'(1);
          end
        end
        S_CHECK: begin
          entry_digits <= '0;
          digit_count  <= '0;
          timer        <= '0;
          if (code_ok) begin
            state      <= S_UNLOCKED;
            fail_count <= '0;
          end else if (fail_count == FAIL_LAST) begin
            state      <= S_LOCKOUT;
            fail_count <= FAIL_SAT;
          end else begin
            state      <= S_ERROR;
            fail_count <= fail_count + FW'(1);
          end
        end
        S_ERROR: begin
          if (timer == ERR_END) begin
            state <= S_ENTRY;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_LOCKOUT: begin
          if (timer == LCK_END) begin
            state      <= S_ENTRY;
            timer      <= '0;
            fail_count <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_UNLOCKED: begin
          if (lock || (timer == UNL_END && !(set_code && full))) begin
            state        <= S_ENTRY;
            entry_digits <= '0;
            digit_count  <= '0;
            timer        <= '0;
          end else if (set_code && full) begin
            code         <= entry_digits;
            entry_digits <= '0;
            digit_count  <= '0;
            timer        <= '0;
          end else if (clear) begin
            entry_digits <= '0;
            digit_count  <= '0;
            timer        <= timer + TW'(1);
          end else if (key_ok) begin
            entry_digits <= shifted;
            digit_count  <= digit_count + CW'(1);
            timer        <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= S_ENTRY;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digital_lock_ctrl.sv
// Scoreboard bench for digital_lock_ctrl: stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_digital_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        enter = 1'b0;
  logic        clear = 1'b0;
  logic        lock = 1'b0;
  logic        set_code = 1'b0;
  logic [15:0] entry_digits;
  logic [2:0]  digit_count;
  logic        unlocked;
  logic        Error;
  logic        lockout;
  logic [1:0]  fail_count;

  digital_lock_ctrl #(
    .NUM_DIGITS    (4),
    .MAX_ATTEMPTS  (3),
    .ERROR_CYCLES  (4),
    .LOCKOUT_CYCLES(8),
    .UNLOCK_CYCLES (16),
    .DEFAULT_CODE  (16'h1234)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .enter       (enter),
    .clear       (clear),
    .lock        (lock),
    .set_code    (set_code),
    .entry_digits(entry_digits),
    .digit_count (digit_count),
    .unlocked    (unlocked),
    .Error       (Error),
    .lockout     (lockout),
    .fail_count  (fail_count)
  );

  always #5 clk = ~clk;

  localparam int DIG = 0;
  localparam int CNT = 1;
  localparam int UNL = 2;
  localparam int ERR = 3;
  localparam int LCK = 4;
  localparam int FC  = 5;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int s);
    case (s)
      DIG:     return 32'(entry_digits);
      CNT:     return 32'(digit_count);
      UNL:     return 32'(unlocked);
      ERR:     return 32'(Error);
      LCK:     return 32'(lockout);
      default: return 32'(fail_count);
    endcase
  endfunction

  function automatic string sname(input int s);
    case (s)
      DIG:     return "entry_digits";
      CNT:     return "digit_count";
      UNL:     return "unlocked";
      ERR:     return "Error";
      LCK:     return "lockout";
      default: return "fail_count";
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t        keep[$];
    logic [31:0] a;
    keep = {};
    foreach (q[i]) begin
      if (q[i].cyc <= cyc) begin
        a = actual(q[i].sig);
        n_checks++;
        if (q[i].cyc < cyc || a !== q[i].val) begin
          n_fail++;
          $display("FAIL %s at edge %0d: actual=%0h required=%0h",
                   sname(q[i].sig), q[i].cyc, a, q[i].val);
        end
      end else begin
        keep.push_back(q[i]);
      end
    end
    q = keep;
    if (rst_n) begin
      n_checks++;
      if (unlocked && Error) begin
        n_fail++;
        $display("FAIL exclusive at edge %0d: unlocked=%b Error=%b required not both",
                 cyc, unlocked, Error);
      end
    end
  end

  task automatic exp_at(input int d, input int s, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc + d;
    e.sig = s;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic drive(input logic kv, input logic [3:0] kd,
                       input logic en, input logic cl,
                       input logic lk, input logic sc);
    key_valid = kv;
    key_digit = kd;
    enter     = en;
    clear     = cl;
    lock      = lk;
    set_code  = sc;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_digit = 4'd0;
    enter     = 1'b0;
    clear     = 1'b0;
    lock      = 1'b0;
    set_code  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key(input logic [3:0] d);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic keys4(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) key(c[4*i +: 4]);
  endtask

  task automatic press_enter();
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_lock();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_at(0, UNL, 0);
    exp_at(0, CNT, 0);
  endtask

  task automatic expect_zero();
    for (int s = DIG; s <= FC; s++) exp_at(0, s, 0);
  endtask

  // Called right after the enter cycle; leaves the DUT in UNLOCKED.
  task automatic check_unlock();
    exp_at(0, UNL, 0);
    exp_at(1, UNL, 1);
    exp_at(1, ERR, 0);
    exp_at(1, FC, 0);
    exp_at(1, CNT, 0);
    idle(1);
  endtask

  // Called right after the enter cycle; returns once back in ENTRY.
  task automatic check_fail(input int f);
    exp_at(0, ERR, 0);
    for (int d = 1; d <= 4; d++) exp_at(d, ERR, 1);
    exp_at(5, ERR, 0);
    exp_at(1, UNL, 0);
    exp_at(1, LCK, 0);
    exp_at(1, FC, f);
    exp_at(4, FC, f);
    idle(5);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    expect_zero();

    // correct default code
    keys4(16'h1234);
    exp_at(0, DIG, 32'h1234);
    exp_at(0, CNT, 4);
    press_enter();
    check_unlock();
    press_lock();

    // single failure, keys ignored while in CHECK/ERROR
    keys4(16'h1235);
    press_enter();
    exp_at(1, FC, 1);
    key(4'd7);
    key(4'd7);
    exp_at(0, CNT, 0);
    exp_at(0, DIG, 0);
    exp_at(0, ERR, 1);
    exp_at(3, ERR, 0);
    exp_at(3, CNT, 0);
    idle(3);
    keys4(16'h1234);
    press_enter();
    check_unlock();
    press_lock();

    // lockout after three failures, one with a partial entry
    keys4(16'h1111);
    press_enter();
    check_fail(1);
    key(4'd5);
    key(4'd6);
    exp_at(0, CNT, 2);
    press_enter();
    check_fail(2);
    keys4(16'h9999);
    press_enter();
    exp_at(0, FC, 2);
    for (int d = 1; d <= 8; d++) begin
      exp_at(d, LCK, 1);
      exp_at(d, ERR, 1);
    end
    exp_at(1, FC, 3);
    exp_at(8, FC, 3);
    exp_at(9, LCK, 0);
    exp_at(9, ERR, 0);
    exp_at(9, FC, 0);
    idle(1);
    key(4'd1);
    exp_at(0, CNT, 0);
    idle(7);
    keys4(16'h1234);
    press_enter();
    check_unlock();
    press_lock();

    // input filtering
    key(4'hA);
    exp_at(0, CNT, 0);
    exp_at(0, DIG, 0);
    keys4(16'h1234);
    key(4'd5);
    exp_at(0, DIG, 32'h1234);
    exp_at(0, CNT, 4);
    drive(1'b1, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_at(0, CNT, 0);
    exp_at(0, DIG, 0);
    keys4(16'h1234);
    drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_at(0, CNT, 0);
    exp_at(1, UNL, 0);
    exp_at(1, ERR, 0);
    exp_at(2, ERR, 0);
    exp_at(2, FC, 0);
    idle(2);

    // code change while unlocked
    keys4(16'h1234);
    press_enter();
    check_unlock();
    keys4(16'h9876);
    exp_at(0, DIG, 32'h9876);
    exp_at(0, CNT, 4);
    exp_at(0, UNL, 1);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_at(0, CNT, 0);
    exp_at(0, DIG, 0);
    exp_at(0, UNL, 1);
    key(4'd5);
    key(4'd5);
    key(4'd5);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_at(0, CNT, 3);
    exp_at(0, DIG, 32'h555);
    press_lock();
    keys4(16'h1234);
    press_enter();
    check_fail(1);
    keys4(16'h9876);
    press_enter();
    exp_at(16, UNL, 1);
    exp_at(17, UNL, 0);
    exp_at(17, CNT, 0);
    check_unlock();
    idle(16);

    // empty entries into lockout, then reset mid-lockout
    press_enter();
    check_fail(1);
    press_enter();
    check_fail(2);
    press_enter();
    exp_at(1, LCK, 1);
    exp_at(1, ERR, 1);
    exp_at(1, FC, 3);
    exp_at(3, LCK, 1);
    idle(3);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    expect_zero();
    keys4(16'h1234);
    press_enter();
    check_unlock();
    press_lock();

    w = 0;
    while (q.size() != 0 && w < 100) begin
      idle(1);
      w++;
    end
    if (q.size() != 0) begin
      foreach (q[i])
        $display("FAIL pending %s at edge %0d: never compared, required=%0h",
                 sname(q[i].sig), q[i].cyc, q[i].val);
      n_fail += q.size();
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
